// File: rtl/rhomboid_pkg.sv
// rtl/rhomboid_pkg.sv - shared types and arithmetic helpers for the rhomboid generator
package rhomboid_pkg;

    // Envelope sequencer states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RISE = 2'd1,
        FALL = 2'd2
    } state_e;

    // Mid-scale code for a w-bit unsigned sample
    function automatic int mid_of(input int w);
        return (1 << (w - 1)) - 1;
    endfunction

    // a+b clipped to lim
    function automatic int sat_add(input int a, input int b, input int lim);
        return (a + b > lim) ? lim : a + b;
    endfunction

    // a-b clipped at zero
    function automatic int sat_sub(input int a, input int b);
        return (a > b) ? a - b : 0;
    endfunction

endpackage

// File: rtl/rhomboid_gen_tick_divider.sv
// rtl/rhomboid_gen_tick_divider.sv - tick_divider: one-clock tick every div+1 enabled clocks
module tick_divider #(
    parameter int DIV_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [DIV_W-1:0] div,
    output logic             tick
);

    logic [DIV_W-1:0] cnt_q;
    logic [DIV_W-1:0] cnt_d;

    // A counter above a freshly lowered div simply runs on to wrap before ticking again
    assign tick = en && (cnt_q == div);

    // Next count: hold at zero while disabled, clear on tick, otherwise count up
    always_comb begin
        cnt_d = cnt_q;
        if (!en) begin
            cnt_d = '0;
        end else if (tick) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Counter register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/rhomboid_gen.sv
// rtl/rhomboid_gen.sv - interleaved mid+env / mid-env diamond source; optional sync output under RHOMBOID_SYNC_EN
module rhomboid_gen
    import rhomboid_pkg::*;
#(
    parameter int W     = 8,
    parameter int DIV_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [W-2:0]     amp,
    input  logic [W-2:0]     step,
    input  logic [DIV_W-1:0] div,
    output logic [W-1:0]     wave,
    output logic             upper,
    output logic             busy
`ifdef RHOMBOID_SYNC_EN
    ,
    output logic             sync
`endif
);

    localparam int           ENV_W   = W - 1;
    localparam logic [W-1:0] MID     = W'(mid_of(W));
    localparam logic [1:0]   ST_IDLE = IDLE;
    localparam logic [1:0]   ST_RISE = RISE;
    localparam logic [1:0]   ST_FALL = FALL;

    logic [1:0]       state_q, state_d;
    logic [ENV_W-1:0] env_q, env_d;
    logic [ENV_W-1:0] amp_l_q, amp_l_d;
    logic [ENV_W-1:0] step_l_q, step_l_d;
    logic             phase_up_q, phase_up_d;
    logic [W-1:0]     wave_q, wave_d;
    logic             upper_q, upper_d;
`ifdef RHOMBOID_SYNC_EN
    logic             sync_q, sync_d;
`endif

    logic             tick;
    logic [ENV_W-1:0] step_now;

    // A zero step would stall the envelope forever, so it is promoted to one
    assign step_now = (step == '0) ? ENV_W'(1) : step;

    tick_divider #(
        .DIV_W (DIV_W)
    ) u_tick_divider (
        .clk  (clk),
        .rst  (rst),
        .en   (en && (state_q != ST_IDLE)),
        .div  (div),
        .tick (tick)
    );

    // Sequencer: one sample per tick, envelope updated after each lower sample
    always_comb begin
        state_d    = state_q;
        env_d      = env_q;
        amp_l_d    = amp_l_q;
        step_l_d   = step_l_q;
        phase_up_d = phase_up_q;
        wave_d     = wave_q;
        upper_d    = upper_q;
`ifdef RHOMBOID_SYNC_EN
        sync_d     = 1'b0;
`endif
        if (!en) begin
            state_d    = ST_IDLE;
            env_d      = '0;
            phase_up_d = 1'b1;
            wave_d     = MID;
            upper_d    = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d    = ST_RISE;
                    amp_l_d    = amp;
                    step_l_d   = step_now;
                    env_d      = '0;
                    phase_up_d = 1'b1;
                end
                ST_RISE, ST_FALL: begin
                    if (tick) begin
                        if (phase_up_q) begin
                            wave_d     = MID + W'(env_q);
                            upper_d    = 1'b1;
                            phase_up_d = 1'b0;
`ifdef RHOMBOID_SYNC_EN
                            // The only env==0 pair of a period is its opening pair
                            sync_d     = (env_q == '0);
`endif
                        end else begin
                            wave_d     = MID - W'(env_q);
                            upper_d    = 1'b0;
                            phase_up_d = 1'b1;
                            if (state_q == ST_RISE) begin
                                if (env_q == amp_l_q) begin
                                    state_d = ST_FALL;
                                    env_d   = ENV_W'(sat_sub(int'(env_q), int'(step_l_q)));
                                end else begin
                                    env_d   = ENV_W'(sat_add(int'(env_q), int'(step_l_q), int'(amp_l_q)));
                                end
                            end else begin
                                if (env_q == '0) begin
                                    // Period boundary: new amp/step govern the climb that follows
                                    state_d  = ST_RISE;
                                    amp_l_d  = amp;
                                    step_l_d = step_now;
                                    env_d    = ENV_W'(sat_add(0, int'(step_now), int'(amp)));
                                end else begin
                                    env_d    = ENV_W'(sat_sub(int'(env_q), int'(step_l_q)));
                                end
                            end
                        end
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // State and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            env_q      <= '0;
            amp_l_q    <= '0;
            step_l_q   <= '0;
            phase_up_q <= 1'b1;
            wave_q     <= MID;
            upper_q    <= 1'b0;
`ifdef RHOMBOID_SYNC_EN
            sync_q     <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            env_q      <= env_d;
            amp_l_q    <= amp_l_d;
            step_l_q   <= step_l_d;
            phase_up_q <= phase_up_d;
            wave_q     <= wave_d;
            upper_q    <= upper_d;
`ifdef RHOMBOID_SYNC_EN
            sync_q     <= sync_d;
`endif
        end
    end

    assign wave  = wave_q;
    assign upper = upper_q;
    assign busy  = (state_q != ST_IDLE);
`ifdef RHOMBOID_SYNC_EN
    assign sync  = sync_q;
`endif

endmodule

// File: doc/rhomboid_gen.md
Name: rhomboid_gen

Overview:
Parametrised successor of the 8-bit rhomboid source in the function generator.
- Emits an interleaved pair of samples, mid+env then mid−env, producing a filled diamond on the scope/DAC.
- Envelope env ramps 0→amp→0 with programmable amplitude, step size and sample-rate prescaler.
- Sits beside the other waveform modules, feeding the output mux/DAC path with a W-bit unsigned sample.

Parameters:
- W, 8, sample width; MID = 2^(W-1)−1 (127 at W=8).
- DIV_W, 16, prescaler counter width.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- en  in  1  run enable; low forces idle
- amp  in  W-1  peak envelope amplitude (0..MID)
- step  in  W-1  envelope increment per sample pair; 0 treated as 1
- div  in  DIV_W  tick every div+1 clocks; 0 = every clock
- wave  out  W  registered sample
- upper  out  1  1 = current wave is mid+env sample, 0 = mid−env sample
- busy  out  1  1 while not IDLE

Behaviour:
- Reset (async, rst=1): wave=MID, upper=0, busy=0, env=0, prescaler=0, state=IDLE, amp/step latches=0.
- Prescaler: counter increments each clk while en=1. Tick when counter==div, then counter clears. All state advances only on tick.
- States:
  - IDLE: en=1 → RISE on the next clk, latching amp_l=amp and step_l=max(step,1); env=0, upper phase next.
  - RISE / FALL: each tick emits one sample.
    - upper phase: wave=MID+env, upper=1.
    - lower phase: wave=MID−env, upper=0, and env updates after this sample.
  - RISE update: env=min(env+step_l, amp_l); if env==amp_l before update → FALL, env=max(env−step_l, 0).
  - FALL update: env=max(env−step_l, 0), saturating; if env==0 before update → RISE and re-latch amp/step (new period).
- amp/step changes mid-period take effect only at the period boundary (env==0 at the FALL→RISE turn).
- amp=0: wave alternates MID, MID (constant MID); state toggles RISE/FALL each pair.
- Period at step=1, amp=A>0: 2A sample pairs = 4A ticks.
- Arithmetic: env is W-1 bits; MID+env ≤ 2^W−2 and MID−env ≥ 0, so no overflow and no wrap is possible.
- en deasserted mid-operation: next clk → IDLE, wave=MID, upper=0, env=0, prescaler=0. Re-enable restarts from env=0.
- div changes take effect immediately. If counter>div, the counter runs to wrap at 2^DIV_W then ticks at the new div (documented, not guarded).
- Latency: first sample (MID, upper=1) appears div+1 clocks after the IDLE→RISE clock.

Optional Feature:
Macro RHOMBOID_SYNC_EN.
- Defined: adds output sync (1 bit), a one-clk pulse coincident with the first upper sample of every period (env=0 after amp/step latch). Reset value 0.
- Undefined: port and logic absent; all other behaviour identical.

Decomposition:
- Package rhomboid_pkg: state enum {IDLE, RISE, FALL}; function mid_of(W); saturating add/sub helpers.
- Sub-module tick_divider (DIV_W): en, div → tick. Reusable by the sibling waveform blocks.

Test Plan:
- W=8, amp=3, step=1, div=0, en=1 → wave 127,127,128,126,129,125,130,124,129,125,128,126,127,127,… repeats every 12 ticks.
- amp=5, step=2, div=0 → envelope 0,2,4,5,3,1,0: wave pairs (127,127),(129,125),(131,123),(132,122),(130,124),(128,126),(127,127).
- div=3, amp=1, step=1 → wave changes every 4 clks; upper toggles each change; first sample 4 clks after start.
- Change amp 3→6 at env=2 while RISE → current period still peaks at 130. Next period peaks at 133 (min 121).
- Assert rst or drop en mid-FALL → wave=127, busy=0, upper=0 at once (rst) / next clk (en). Restart begins at 127 upper.
- amp=127, step=0 → peak pair (254,0), period 508 ticks. With RHOMBOID_SYNC_EN, sync pulses every 508 ticks.
